pico_key_requester: RTL and testbench
=====================================

PICO_KEY_REQUESTER -- requirements
Module: pico_key_requester

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: key-event queue depth, power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 25000000: maximum wait per handshake phase, equal to 1 s at 25 MHz.
REQ-003 Parameter EQUAL_CODE, default 8'h3D: key code that requests an equality check.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; clk and reset are the first two ports below.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- key_valid  in  1  key event strobe
- key_code  in  8  key code, sampled when key_valid=1
- key_ready  out  1  queue can accept an event
- start  out  8  request word to the PicoBlaze start port
- select_key  out  8  key code presented to the PicoBlaze
- check_equal  out  8  equality-check request word
- interrupt_in  out  1  one-cycle pulse that wakes the PicoBlaze
- done  in  8  PicoBlaze completion word; bit 0 is significant
- equal_done  in  8  PicoBlaze equality completion word; bit 0 is significant
- out_sel  in  8  phrase index produced by the PicoBlaze
- play_req  out  1  one-cycle pulse requesting audio playback
- play_sel  out  8  phrase index for the audio player
- play_done  in  1  audio player finished
- busy  out  1  FSM is not in IDLE, or the queue is not empty
- timeout_err  out  1  sticky flag: a handshake timed out

Function
REQ-005 key_ready SHALL be 1 exactly when the queue holds fewer than FIFO_DEPTH entries.
REQ-006 A push SHALL occur on a cycle where key_valid=1 and key_ready=1; key_valid while full SHALL be dropped silently.
REQ-007 A push and a pop in the same cycle SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-008 The FSM SHALL have the states IDLE, ISSUE, WAIT_DONE, RELEASE, PLAY, WAIT_PLAY.
REQ-009 IDLE -> ISSUE when the queue is not empty; the head entry SHALL be popped on that same transition and held in the current-code register cur.
REQ-010 The ISSUE state SHALL last 1 cycle and SHALL set the following outputs:
- start=8'h01
- select_key=cur
- check_equal=8'h01 if cur==EQUAL_CODE, else 8'h00
- interrupt_in=1 for that cycle only
REQ-011 The ISSUE state SHALL then move to WAIT_DONE.
REQ-012 start, select_key and check_equal SHALL hold their values through WAIT_DONE.
REQ-013 In WAIT_DONE, the completion bit SHALL be equal_done[0] for an equality request and done[0] otherwise.
REQ-014 When the completion bit is 1, the block SHALL capture out_sel into play_sel, set start and check_equal to 0, and move to RELEASE.
REQ-015 RELEASE SHALL wait until the completion bit returns to 0 (four-phase handshake), then move to PLAY.
REQ-016 PLAY SHALL pulse play_req for 1 cycle, then move to WAIT_PLAY.
REQ-017 WAIT_PLAY -> IDLE on play_done=1.
REQ-018 Minimum latency from the pop to play_req SHALL be 4 cycles (ISSUE, WAIT_DONE, RELEASE, PLAY) when the PicoBlaze responds instantly.
REQ-019 A timeout counter SHALL clear on every state change and increment in WAIT_DONE, RELEASE and WAIT_PLAY.
REQ-020 When the counter reaches TIMEOUT_CYCLES-1, the block SHALL set timeout_err, discard cur, set start and check_equal to 0, and go to IDLE without asserting play_req.
REQ-021 timeout_err SHALL clear only on reset.
REQ-022 A completion bit already at 1 when WAIT_DONE is entered SHALL be accepted on the first WAIT_DONE cycle.

Reset
REQ-023 Reset SHALL empty the queue, put the FSM in IDLE, and clear the timeout counter.
REQ-024 Reset SHALL drive the following outputs to these values:
- start=0, select_key=0, check_equal=0
- interrupt_in=0, play_req=0, play_sel=0
- timeout_err=0, busy=0, key_ready=1
REQ-025 Reset asserted mid-handshake SHALL abort the handshake with no play_req and no interrupt_in on the following cycle.

Structure
REQ-026 The FSM state encoding, the request-word constants 8'h01 and 8'h00, and the EQUAL_CODE default SHALL live in a shared package, pico_if_pkg.
REQ-027 The key queue SHALL be one sub-module, key_fifo, holding 8-bit entries with push, pop, full, empty and count signals.

Verification
REQ-028 Single key 8'h31 with done raised 3 cycles after interrupt_in and out_sel=8'h05 -> select_key=8'h31, check_equal=0, and one play_req with play_sel=8'h05.
REQ-029 Key 8'h3D with equal_done raised and done held at 0 -> check_equal=8'h01, and the handshake completes on equal_done.
REQ-030 Five keys pushed back-to-back while the FSM is stalled in WAIT_PLAY -> the 5th key is dropped, key_ready=0 after the 4th, and the four keys are replayed in order.
REQ-031 TIMEOUT_CYCLES=16 with done never rising -> timeout_err=1 after 16 WAIT_DONE cycles, FSM returns to IDLE, next key is processed normally.
REQ-032 Reset asserted in RELEASE -> all outputs reach reset values next cycle, queue empty, no play_req.
REQ-033 Push and pop in the same cycle at occupancy 4 -> occupancy stays 4; at occupancy 0 with a push in IDLE -> key is issued the following cycle.

Source files
------------

// File: rtl/pico_if_pkg.sv
// Shared definitions for the PicoBlaze key requester: FSM states and
// request-word constants.
package pico_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_PLAY      = 3'd4,
        ST_WAIT_PLAY = 3'd5
    } state_t;

    localparam logic [7:0] REQ_ON             = 8'h01;
    localparam logic [7:0] REQ_OFF            = 8'h00;
    localparam logic [7:0] EQUAL_CODE_DEFAULT = 8'h3D;

    // States in which the handshake watchdog counts.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WAIT_DONE) || (s == ST_RELEASE) || (s == ST_WAIT_PLAY);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Key-event queue: 8-bit entries, first-word-fall-through head, pointers
// wrapping modulo DEPTH (power of two).
module key_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           push_ok, pop_ok;
    logic [DEPTH-1:0] wr_en;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_ok && (wr_ptr_q == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_q[i] <= din;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pico_key_requester.sv
// Queues key events and runs a four-phase request/complete handshake with a
// PicoBlaze, then asks the audio player to play the returned phrase.
module pico_key_requester
    import pico_if_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 25000000,
    parameter logic [7:0] EQUAL_CODE     = EQUAL_CODE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       key_ready,
    output logic [7:0] start,
    output logic [7:0] select_key,
    output logic [7:0] check_equal,
    output logic       interrupt_in,
    input  logic [7:0] done,
    input  logic [7:0] equal_done,
    input  logic [7:0] out_sel,
    output logic       play_req,
    output logic [7:0] play_sel,
    input  logic       play_done,
    output logic       busy,
    output logic       timeout_err
);

    localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]                    fifo_dout;
    logic                          fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     cur_q, cur_d;
    logic           eq_q, eq_d;
    logic [7:0]     start_q, start_d;
    logic [7:0]     check_q, check_d;
    logic           irq_q, irq_d;
    logic           play_req_q, play_req_d;
    logic [7:0]     play_sel_q, play_sel_d;
    logic           terr_q, terr_d;
    logic           compl_bit, timed_out, abort;
    logic           unused_bits;

    assign key_ready = !fifo_full;
    assign fifo_push = key_valid && key_ready;

    key_fifo #(.DEPTH(FIFO_DEPTH)) u_key_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (key_code),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Only bit 0 of each completion word carries meaning.
    assign unused_bits = ^{done[7:1], equal_done[7:1]};
    assign compl_bit   = eq_q ? equal_done[0] : done[0];
    assign timed_out   = (timer_q == TIMER_LAST);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cur_d      = cur_q;
        eq_d       = eq_q;
        start_d    = start_q;
        check_d    = check_q;
        irq_d      = 1'b0;
        play_req_d = 1'b0;
        play_sel_d = play_sel_q;
        terr_d     = terr_q;
        fifo_pop   = 1'b0;
        abort      = 1'b0;

        if (is_wait_state(state_q)) begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_dout;
                    eq_d     = (fifo_dout == EQUAL_CODE);
                    start_d  = REQ_ON;
                    check_d  = (fifo_dout == EQUAL_CODE) ? REQ_ON : REQ_OFF;
                    irq_d    = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (compl_bit) begin
                    play_sel_d = out_sel;
                    start_d    = REQ_OFF;
                    check_d    = REQ_OFF;
                    state_d    = ST_RELEASE;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!compl_bit) begin
                    play_req_d = 1'b1;
                    state_d    = ST_PLAY;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            ST_PLAY: begin
                state_d = ST_WAIT_PLAY;
            end
            ST_WAIT_PLAY: begin
                if (play_done) begin
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            terr_d  = 1'b1;
            cur_d   = 8'h00;
            eq_d    = 1'b0;
            start_d = REQ_OFF;
            check_d = REQ_OFF;
            state_d = ST_IDLE;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            cur_q      <= 8'h00;
            eq_q       <= 1'b0;
            start_q    <= REQ_OFF;
            check_q    <= REQ_OFF;
            irq_q      <= 1'b0;
            play_req_q <= 1'b0;
            play_sel_q <= 8'h00;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cur_q      <= cur_d;
            eq_q       <= eq_d;
            start_q    <= start_d;
            check_q    <= check_d;
            irq_q      <= irq_d;
            play_req_q <= play_req_d;
            play_sel_q <= play_sel_d;
            terr_q     <= terr_d;
        end
    end

    assign start        = start_q;
    assign select_key   = cur_q;
    assign check_equal  = check_q;
    assign interrupt_in = irq_q;
    assign play_req     = play_req_q;
    assign play_sel     = play_sel_q;
    assign timeout_err  = terr_q;
    assign busy         = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_pico_key_requester.sv
// Self-checking bench: the bench plays the PicoBlaze and the audio player and
// checks each handshake against expectations built from the protocol rules.
module tb_pico_key_requester;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       reset, key_valid, key_ready, interrupt_in, play_req, play_done, busy, timeout_err;
    logic [7:0] key_code, start, select_key, check_equal, done, equal_done, out_sel, play_sel;

    logic       f_push, f_pop, f_full, f_empty;
    logic [7:0] f_din, f_dout;
    logic [2:0] f_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int play_cnt     = 0;
    int irq_cnt      = 0;

    typedef struct {
        logic [7:0] key, chk, st, hold_key, hold_chk, hold_st, sel;
        int         lat;
        bit         ok;
    } obs_t;

    always #5 clk = ~clk;

    pico_key_requester #(
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .EQUAL_CODE(8'h3D)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .start(start), .select_key(select_key),
        .check_equal(check_equal), .interrupt_in(interrupt_in), .done(done),
        .equal_done(equal_done), .out_sel(out_sel), .play_req(play_req),
        .play_sel(play_sel), .play_done(play_done), .busy(busy),
        .timeout_err(timeout_err)
    );

    key_fifo #(.DEPTH(DEPTH)) u_fifo_probe (
        .clk(clk), .reset(reset), .push(f_push), .din(f_din), .pop(f_pop),
        .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
    );

    always @(negedge clk) begin
        if (play_req === 1'b1)     play_cnt++;
        if (interrupt_in === 1'b1) irq_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1; key_valid = 1'b0; key_code = 8'h00; done = 8'h00;
        equal_done = 8'h00; out_sel = 8'h00; play_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_key(input logic [7:0] code);
        key_valid = 1'b1; key_code = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Acts as PicoBlaze plus audio player for one request; no checking here.
    task automatic pico_serve(input bit use_eq, input int delay, input logic [7:0] sel,
                              input int play_delay, output obs_t o);
        int cyc;
        bit raised, accepted;
        o = '{default: 0};
        o.lat = -1;
        cyc = 0;
        while (interrupt_in !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        if (interrupt_in !== 1'b1) return;
        o.key = select_key; o.chk = check_equal; o.st = start;
        cyc = 0; raised = 0; accepted = 0;
        while (!accepted && cyc < 40) begin
            if (raised && start === 8'h00) begin
                accepted = 1;
                if (use_eq) equal_done = {7'($urandom), 1'b0};
                else        done       = {7'($urandom), 1'b0};
            end else begin
                if (cyc >= 1) begin
                    o.hold_key = select_key; o.hold_chk = check_equal; o.hold_st = start;
                end
                if (cyc == delay) begin
                    out_sel = sel; raised = 1;
                    if (use_eq) equal_done = {7'($urandom), 1'b1};
                    else        done       = {7'($urandom), 1'b1};
                end
                @(negedge clk); cyc++;
            end
        end
        if (!accepted) return;
        while (play_req !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
        if (play_req !== 1'b1) return;
        o.lat = cyc; o.sel = play_sel;
        if (play_delay >= 0) begin
            @(negedge clk);
            repeat (play_delay) @(negedge clk);
            play_done = 1'b1;
            @(negedge clk);
            play_done = 1'b0;
        end
        o.ok = 1;
        $display("[TB] key=%h chk=%h sel=%h lat=%0d", o.key, o.chk, o.sel, o.lat);
    endtask

    task automatic test_reset();
        tests_run++; if (start !== 8'h00 || select_key !== 8'h00 || check_equal !== 8'h00) begin
            tests_failed++; $display("FAIL reset_words: got %h/%h/%h want 00/00/00", start, select_key, check_equal); end
        tests_run++; if (interrupt_in !== 1'b0 || play_req !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pulses: got irq=%b play=%b want 0/0", interrupt_in, play_req); end
        tests_run++; if (play_sel !== 8'h00) begin
            tests_failed++; $display("FAIL reset_play_sel: got %h want 00", play_sel); end
        tests_run++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: got terr=%b busy=%b want 0/0", timeout_err, busy); end
        tests_run++; if (key_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
    endtask

    task automatic test_single();
        obs_t o; int p0, i0;
        p0 = play_cnt; i0 = irq_cnt;
        push_key(8'h31);
        pico_serve(1'b0, 3, 8'h05, 1, o);
        @(negedge clk);
        tests_run++; if (o.ok !== 1'b1) begin tests_failed++; $display("FAIL single_done: got ok=%b want 1", o.ok); end
        tests_run++; if (o.key !== 8'h31 || o.st !== 8'h01 || o.chk !== 8'h00) begin
            tests_failed++; $display("FAIL single_issue: got key=%h start=%h chk=%h want 31/01/00", o.key, o.st, o.chk); end
        tests_run++; if (o.hold_key !== 8'h31 || o.hold_st !== 8'h01 || o.hold_chk !== 8'h00) begin
            tests_failed++; $display("FAIL single_hold: got key=%h start=%h chk=%h want 31/01/00", o.hold_key, o.hold_st, o.hold_chk); end
        tests_run++; if (o.sel !== 8'h05) begin tests_failed++; $display("FAIL single_play_sel: got %h want 05", o.sel); end
        // done raised 3 cycles after the interrupt, accepted in WAIT_DONE, then RELEASE and PLAY
        tests_run++; if (o.lat !== 5) begin tests_failed++; $display("FAIL single_latency: got %0d want 5", o.lat); end
        tests_run++; if (play_cnt - p0 !== 1 || irq_cnt - i0 !== 1) begin
            tests_failed++; $display("FAIL single_pulses: got play=%0d irq=%0d want 1/1", play_cnt - p0, irq_cnt - i0); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_equal();
        obs_t o; logic [7:0] sel;
        sel = 8'($urandom);
        done = 8'h00;
        push_key(8'h3D);
        pico_serve(1'b1, 2, sel, 0, o);
        tests_run++; if (o.ok !== 1'b1 || o.chk !== 8'h01 || o.hold_chk !== 8'h01) begin
            tests_failed++; $display("FAIL equal_request: got ok=%b chk=%h hold=%h want 1/01/01", o.ok, o.chk, o.hold_chk); end
        tests_run++; if (o.sel !== sel) begin tests_failed++; $display("FAIL equal_play_sel: got %h want %h", o.sel, sel); end
        tests_run++; if (o.lat !== 4) begin tests_failed++; $display("FAIL equal_latency: got %0d want 4", o.lat); end
    endtask

    task automatic test_min_latency();
        obs_t o; logic [7:0] sel;
        sel = 8'($urandom);
        done = 8'h01; out_sel = sel;
        push_key(8'h42);
        pico_serve(1'b0, 0, sel, 0, o);
        // play_req in the 4th cycle counting ISSUE as the 1st
        tests_run++; if (o.ok !== 1'b1 || o.lat !== 3) begin
            tests_failed++; $display("FAIL min_latency: got ok=%b lat=%0d want 1/3", o.ok, o.lat); end
        tests_run++; if (o.sel !== sel) begin tests_failed++; $display("FAIL min_latency_sel: got %h want %h", o.sel, sel); end
    endtask

    task automatic test_fifo_full();
        obs_t o; logic [7:0] exp_q[$]; logic [7:0] k, want; int occ, i0;
        i0 = irq_cnt; occ = 0;
        push_key(8'h10);
        pico_serve(1'b0, 1, 8'h11, -1, o);
        for (int i = 0; i < 5; i++) begin
            k = 8'($urandom_range(0, 200));
            tests_run++; if (key_ready !== (occ < DEPTH)) begin
                tests_failed++; $display("FAIL full_key_ready%0d: got %b want %b", i, key_ready, occ < DEPTH); end
            if (occ < DEPTH) begin exp_q.push_back(k); occ++; end
            key_valid = 1'b1; key_code = k;
            @(negedge clk);
        end
        key_valid = 1'b0;
        play_done = 1'b1;
        @(negedge clk);
        play_done = 1'b0;
        // Queue is full while IDLE pops the head: this key must be dropped.
        tests_run++; if (key_ready !== 1'b0) begin tests_failed++; $display("FAIL full_at_pop: got %b want 0", key_ready); end
        key_valid = 1'b1; key_code = 8'hEE;
        @(negedge clk);
        key_valid = 1'b0;
        tests_run++; if (key_ready !== 1'b1 || interrupt_in !== 1'b1) begin
            tests_failed++; $display("FAIL full_after_pop: got ready=%b irq=%b want 1/1", key_ready, interrupt_in); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            pico_serve(want == 8'h3D, int'($urandom_range(0, 3)), want ^ 8'h5A, 0, o);
            tests_run++; if (o.ok !== 1'b1 || o.key !== want || o.sel !== (want ^ 8'h5A)) begin
                tests_failed++; $display("FAIL full_replay: got ok=%b key=%h sel=%h want 1/%h/%h", o.ok, o.key, o.sel, want, want ^ 8'h5A); end
        end
        repeat (3) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || irq_cnt - i0 !== 5) begin
            tests_failed++; $display("FAIL full_drop: got busy=%b issued=%0d want 0/5", busy, irq_cnt - i0); end
    endtask

    task automatic test_fifo_same_cycle();
        logic [7:0] q[$]; logic [7:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'($urandom); q.push_back(v);
            f_push = 1'b1; f_din = v;
            @(negedge clk);
        end
        f_push = 1'b0;
        tests_run++; if (f_count !== 3'd4 || f_full !== 1'b1) begin
            tests_failed++; $display("FAIL fifo_fill: got count=%0d full=%b want 4/1", f_count, f_full); end
        v = 8'($urandom);
        f_push = 1'b1; f_pop = 1'b1; f_din = v;
        tests_run++; if (f_dout !== q[0]) begin tests_failed++; $display("FAIL fifo_head: got %h want %h", f_dout, q[0]); end
        @(negedge clk);
        f_push = 1'b0; f_pop = 1'b0;
        void'(q.pop_front()); q.push_back(v);
        tests_run++; if (f_count !== 3'd4) begin tests_failed++; $display("FAIL fifo_same_cycle: got %0d want 4", f_count); end
        for (int i = 0; i < DEPTH; i++) begin
            v = q.pop_front();
            tests_run++; if (f_dout !== v) begin tests_failed++; $display("FAIL fifo_order%0d: got %h want %h", i, f_dout, v); end
            f_pop = 1'b1;
            @(negedge clk);
        end
        f_pop = 1'b0;
        tests_run++; if (f_empty !== 1'b1 || f_count !== 3'd0) begin
            tests_failed++; $display("FAIL fifo_drain: got empty=%b count=%0d want 1/0", f_empty, f_count); end
    endtask

    task automatic test_timeout();
        obs_t o; int cyc, p0; logic [7:0] sel;
        tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_pre: got %b want 0", timeout_err); end
        p0 = play_cnt;
        done = 8'h00; equal_done = 8'h00;
        push_key(8'h55);
        cyc = 0;
        while (interrupt_in !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        cyc = 0;
        while (timeout_err !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        // 1 ISSUE cycle plus 16 WAIT_DONE cycles before the flag is visible
        tests_run++; if (cyc !== TMO + 1) begin tests_failed++; $display("FAIL timeout_cycles: got %0d want %0d", cyc, TMO + 1); end
        tests_run++; if (busy !== 1'b0 || start !== 8'h00 || play_cnt !== p0) begin
            tests_failed++; $display("FAIL timeout_abort: got busy=%b start=%h plays=%0d want 0/00/0", busy, start, play_cnt - p0); end
        sel = 8'($urandom);
        push_key(8'h66);
        pico_serve(1'b0, 2, sel, 1, o);
        tests_run++; if (o.ok !== 1'b1 || o.key !== 8'h66 || o.sel !== sel) begin
            tests_failed++; $display("FAIL timeout_recover: got ok=%b key=%h sel=%h want 1/66/%h", o.ok, o.key, o.sel, sel); end
        tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int n, p0, i0;
        push_key(8'h77);
        push_key(8'h78);
        n = 0;
        while (interrupt_in !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        out_sel = 8'h9A; done = 8'h01;
        n = 0;
        while (start !== 8'h00 && n < 10) begin @(negedge clk); n++; end
        p0 = play_cnt; i0 = irq_cnt;
        reset = 1'b1; done = 8'h00;
        @(negedge clk);
        tests_run++; if (start !== 8'h00 || select_key !== 8'h00 || check_equal !== 8'h00 || play_sel !== 8'h00) begin
            tests_failed++; $display("FAIL midreset_words: got %h/%h/%h/%h want 00/00/00/00", start, select_key, check_equal, play_sel); end
        tests_run++; if (interrupt_in !== 1'b0 || play_req !== 1'b0 || timeout_err !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_flags: got irq=%b play=%b terr=%b want 0/0/0", interrupt_in, play_req, timeout_err); end
        tests_run++; if (busy !== 1'b0 || key_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_queue: got busy=%b ready=%b want 0/1", busy, key_ready); end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++; if (play_cnt !== p0 || irq_cnt !== i0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_quiet: got plays=%0d irqs=%0d busy=%b want 0/0/0", play_cnt - p0, irq_cnt - i0, busy); end
    endtask

    task automatic test_random();
        obs_t o; logic [7:0] k, sel; int dly, want_lat;
        for (int t = 0; t < 16; t++) begin
            k   = ($urandom_range(0, 3) == 0) ? 8'h3D : 8'($urandom);
            sel = 8'($urandom);
            dly = int'($urandom_range(0, 6));
            want_lat = ((dly < 1) ? 1 : dly) + 2;
            push_key(k);
            pico_serve(k == 8'h3D, dly, sel, int'($urandom_range(0, 3)), o);
            tests_run++; if (o.ok !== 1'b1 || o.key !== k || o.chk !== ((k == 8'h3D) ? 8'h01 : 8'h00)) begin
                tests_failed++; $display("FAIL rand_issue%0d: got ok=%b key=%h chk=%h want 1/%h/%0d", t, o.ok, o.key, o.chk, k, k == 8'h3D); end
            tests_run++; if (o.sel !== sel || o.lat !== want_lat) begin
                tests_failed++; $display("FAIL rand_play%0d: got sel=%h lat=%0d want %h/%0d", t, o.sel, o.lat, sel, want_lat); end
        end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rand_idle: got busy=%b want 0", busy); end
    endtask

    initial begin
        f_push = 1'b0; f_pop = 1'b0; f_din = 8'h00;
        do_reset();
        test_reset();
        test_single();
        test_equal();
        test_min_latency();
        test_fifo_full();
        test_fifo_same_cycle();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
